// File: rtl/maxnet_initiator.sv
// maxnet_initiator: starts a maxnet run, waits for done, captures the result and delivers it over valid/ready.
// Optional WAIT timeout with sticky err is compiled in with MAXNET_INITIATOR_TIMEOUT_EN.
module maxnet_initiator #(
  parameter int START_LEN = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             busy,
  output logic             mn_start,
  input  logic             mn_done,
  input  logic [31:0]      mn_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] last_lat,
  output logic             err
);
  if (START_LEN < 1 || START_LEN > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("maxnet_initiator: START_LEN must be 1..15 and TIMEOUT >= 1");
  end
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT, HOLD, ABORT} state_t;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
`endif
  state_t             state_q, state_d;
  logic [3:0]         st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]   lat_q, lat_d, lat_inc;
  logic [31:0]        data_q, data_d;
  logic [CNT_W-1:0]   last_lat_q, last_lat_d;
  logic [CNT_W-1:0]   run_count_q, run_count_d;
  assign lat_inc = &lat_q ? lat_q : lat_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    st_cnt_d    = st_cnt_q;
    lat_d       = lat_q;
    data_d      = data_q;
    last_lat_d  = last_lat_q;
    run_count_d = run_count_q;
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
    wcnt_d      = wcnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        state_d  = START;
        st_cnt_d = 4'd1;
        lat_d    = {{(CNT_W-1){1'b0}}, 1'b1};
      end
      START: begin
        lat_d    = lat_inc;
        st_cnt_d = st_cnt_q + 4'd1;
        if (st_cnt_q == 4'(START_LEN)) state_d = WAIT;
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
        wcnt_d = {{(TW-1){1'b0}}, 1'b1};
`endif
      end
      WAIT: if (mn_done) begin
        data_d     = mn_result;
        last_lat_d = lat_q;
        state_d    = HOLD;
      end else begin
        lat_d = lat_inc;
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
        if (wcnt_q >= TW'(TIMEOUT)) state_d = ABORT;
        else wcnt_d = wcnt_q + 1'b1;
`endif
      end
      HOLD: if (out_ready) begin
        run_count_d = run_count_q + 1'b1;
        state_d     = IDLE;
      end
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
      ABORT: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      st_cnt_q    <= '0;
      lat_q       <= '0;
      data_q      <= '0;
      last_lat_q  <= '0;
      run_count_q <= '0;
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
      wcnt_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      st_cnt_q    <= st_cnt_d;
      lat_q       <= lat_d;
      data_q      <= data_d;
      last_lat_q  <= last_lat_d;
      run_count_q <= run_count_d;
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
`endif
    end
  assign busy      = state_q != IDLE;
  assign mn_start  = state_q == START;
  assign out_valid = state_q == HOLD;
  assign out_data  = data_q;
  assign run_count = run_count_q;
  assign last_lat  = last_lat_q;
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_maxnet_initiator.sv
// tb_maxnet_initiator: directed and random runs checked every cycle against a run-level model.
module tb_maxnet_initiator;
  localparam int SL = 3, TO = 8, CW = 16;
  logic clk = 0, rst = 0, req = 0, mn_done = 0, out_ready = 0;
  logic [31:0] mn_result = 0;
  logic busy, mn_start, out_valid, err;
  logic [31:0] out_data;
  logic [CW-1:0] run_count, last_lat;

  maxnet_initiator #(.START_LEN(SL), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .mn_start(mn_start),
    .mn_done(mn_done), .mn_result(mn_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .run_count(run_count),
    .last_lat(last_lat), .err(err));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a run is active, has an age in cycles since its first start cycle,
  // and either holds a captured result or is still waiting.
  bit m_act, m_cap, m_abort, m_err;
  int m_age, m_cnt, m_lat;
  logic [31:0] m_data;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_act = 0; m_cap = 0; m_abort = 0; m_err = 0; m_age = 0; m_cnt = 0; m_lat = 0; m_data = 0;
    end else if (!m_act) begin
      if (req) begin m_act = 1; m_cap = 0; m_age = 1; end
    end else if (m_abort) begin
      m_abort = 0; m_act = 0; m_err = 1;
    end else if (m_cap) begin
      if (out_ready) begin m_act = 0; m_cap = 0; m_cnt = (m_cnt + 1) % (1 << CW); end
    end else if (m_age > SL && mn_done) begin
      m_cap = 1; m_data = mn_result; m_lat = m_age > (1 << CW) - 1 ? (1 << CW) - 1 : m_age;
    end else begin
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
      if (m_age > SL && m_age - SL >= TO) m_abort = 1;
`endif
      m_age++;
    end

  always @(negedge clk) if (!rst) begin
    chk("busy", busy, m_act);
    chk("mn_start", mn_start, m_act && !m_cap && !m_abort && m_age <= SL);
    chk("out_valid", out_valid, m_cap);
    chk("out_data", out_data, m_data);
    chk("run_count", run_count, m_cnt);
    chk("last_lat", last_lat, m_lat);
    chk("err", err, m_err);
  end

  // Stub maxnet: done pulses dly cycles after mn_start rises, or stays stuck high.
  int cyc_n = 0, age = 1000, dly = 10, nstart = 0;
  bit stub = 1, stuck = 0, prev_start = 0;
  int starts[$];
  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (mn_start && !prev_start) begin age = 0; starts.push_back(cyc_n); end
    else age++;
    if (mn_start) nstart++;
    prev_start = mn_start;
    if (stub) mn_done = stuck || (age == dly);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] d;
    int rc, h;
    bit seen_valid;
    #1 rst = 1;
    step();
    chk("rst_busy", busy, 0); chk("rst_start", mn_start, 0); chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0); chk("rst_count", run_count, 0); chk("rst_lat", last_lat, 0);
    chk("rst_err", err, 0);
    rst = 0;
    step();
    // basic run
    mn_result = 32'h4120_0000; out_ready = 1; dly = 10; nstart = 0;
    req = 1; step(); req = 0;
    wait_valid();
    chk("basic_data", out_data, 32'h4120_0000);
    chk("basic_lat", last_lat, 11);
    chk("basic_nstart", nstart, SL);
    step();
    chk("basic_count", run_count, 1);
    chk("basic_valid_drop", out_valid, 0);
    // back-pressure
    out_ready = 0; mn_result = $urandom; dly = 6;
    req = 1; step(); req = 0;
    wait_valid();
    d = out_data; rc = run_count;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1); chk("bp_data", out_data, d);
      step();
    end
    chk("bp_valid6", out_valid, 1);
    out_ready = 1; step();
    chk("bp_count", run_count, (rc + 1) % (1 << CW));
    chk("bp_done", out_valid, 0);
    // req held high while busy
    dly = 4; starts.delete(); h = 0; req = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid && out_ready && h == 0) h = cyc_n;
    end
    req = 0;
    begin
      int g = -1;
      foreach (starts[i]) if (g < 0 && starts[i] > h) g = starts[i] - h;
      chk("restart_gap", g, 2);
    end
    wait_idle();
    // stale done stuck high
    stuck = 1; mn_result = 32'hDEAD_BEEF;
    req = 1; step(); req = 0;
    wait_valid();
    chk("stale_lat", last_lat, SL + 1);
    chk("stale_data", out_data, 32'hDEAD_BEEF);
    stuck = 0; step(); wait_idle();
    // async reset mid-WAIT
    dly = 1000; req = 1; step(); req = 0;
    repeat (SL + 2) step();
    @(posedge clk); #2 rst = 1; #1;
    chk("arst_busy", busy, 0); chk("arst_start", mn_start, 0);
    chk("arst_valid", out_valid, 0); chk("arst_count", run_count, 0);
    #1 rst = 0;
    step();
`ifdef MAXNET_INITIATOR_TIMEOUT_EN
    seen_valid = 0; req = 1; step(); req = 0;
    for (int i = 0; i < SL + TO + 6; i++) begin step(); if (out_valid) seen_valid = 1; end
    chk("to_err", err, 1); chk("to_novalid", seen_valid, 0);
    dly = 5; mn_result = 32'h1234_5678; req = 1; step(); req = 0;
    wait_valid();
    chk("to_next_data", out_data, 32'h1234_5678); chk("to_err_sticky", err, 1);
    step();
`else
    seen_valid = 0;
`endif
    // random traffic
    stub = 0;
    repeat (600) begin
      step();
      req = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 3) != 0) mn_done = $urandom_range(0, 4) == 0;
      out_ready = $urandom_range(0, 1);
      mn_result = $urandom;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/maxnet_initiator.md
Name: maxnet_initiator

Overview:
- Initiator and consumer for the maxnet engine.
- Accepts a run request from the system, issues the start pulse to maxnet, waits for its done, and captures the 32-bit winner result.
- Presents the result downstream over a valid/ready handshake and keeps run statistics.
- Sits between the system control/sequencer and the maxnet instance; it is the other end of maxnet's start/done/result interface.

Parameters:
- START_LEN, 1, number of cycles mn_start is held high per run (1..15).
- TIMEOUT, 1024, maximum cycles in WAIT before abort; used only when the timeout feature is compiled in.
- CNT_W, 16, width of run_count and of the last-latency register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  run request; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- mn_start  output  1  start to maxnet.
- mn_done  input  1  done from maxnet; level or pulse.
- mn_result  input  32  maxnet result; valid in the cycle mn_done is high.
- out_valid  output  1  captured result is available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  captured result.
- run_count  output  CNT_W  completed, delivered runs.
- last_lat  output  CNT_W  cycles from first mn_start cycle to mn_done for the last run.
- err  output  1  sticky timeout flag; tied 0 when the timeout feature is absent.

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs are 0: busy, mn_start, out_valid, out_data, run_count, last_lat, err. Internal counters cleared.
- States: IDLE, START, WAIT, HOLD, ABORT.
- IDLE:
  - req=1 -> START next cycle.
  - req ignored in all other states; no queueing.
- START:
  - mn_start=1 for exactly START_LEN consecutive cycles, then -> WAIT.
  - Latency counter starts at 1 in the first START cycle.
  - mn_done seen during START is ignored (stale completion from a previous run).
- WAIT:
  - mn_start=0; latency counter increments each cycle, saturating at all-ones.
  - mn_done=1 in a cycle -> out_data<=mn_result, last_lat<=counter, -> HOLD.
  - The result is captured exactly once, on the first mn_done cycle in WAIT.
- HOLD:
  - out_valid=1; out_data stable until accepted.
  - out_valid & out_ready -> run_count++ (wraps modulo 2^CNT_W), out_valid=0, -> IDLE.
  - Earliest restart: req high in the IDLE cycle after the handshake gives mn_start two cycles after the handshake cycle.
  - out_ready high on entry to HOLD -> handshake completes in the first HOLD cycle (1-cycle HOLD).
- ABORT: timeout feature only; see Optional Feature.
- Latency req->mn_start: 1 cycle. mn_done->out_valid: 1 cycle.
- mn_done held high across runs: only the WAIT-state sample counts. A done still high when the next START begins is ignored until WAIT.
- out_data keeps its last value after the handshake; it is not cleared.
- Reset mid-run: all state is abandoned immediately and mn_start drops asynchronously. The maxnet instance shares rst and is reset with it.

Optional Feature:
- Macro: MAXNET_INITIATOR_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles. Reaching TIMEOUT cycles without mn_done -> ABORT.
  - ABORT lasts one cycle: err<=1 (sticky until rst), no out_valid, run_count unchanged, then -> IDLE.
  - mn_done and TIMEOUT reached in the same cycle -> done wins and the result is captured.
- Undefined:
  - No ABORT state; WAIT waits indefinitely.
  - err is constant 0 and TIMEOUT is unused.

Test Plan:
- Basic run: reset, req=1 one cycle, stub maxnet asserts mn_done 10 cycles after mn_start rises with mn_result=32'h4120_0000, out_ready=1 -> mn_start high 1 cycle; out_valid 1 cycle after done with out_data=32'h4120_0000; last_lat=11; run_count=1.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stay stable for 5 cycles; accepted on the 6th; run_count increments once only.
- Request ignored while busy: req held high throughout, done latency 4 -> exactly one mn_start per run; second mn_start occurs 2 cycles after the first handshake.
- Stale done: mn_done stuck at 1 from the previous run with START_LEN=3 -> no capture during the 3 START cycles; capture in the first WAIT cycle.
- Async reset mid-WAIT: rst pulsed between clock edges -> busy, mn_start and out_valid drop to 0 without a clock edge; run_count=0.
- Timeout, with MAXNET_INITIATOR_TIMEOUT_EN and TIMEOUT=8: mn_done never asserted -> ABORT after 8 WAIT cycles; err=1 and stays 1; no out_valid; the next req runs normally.
